// File: rtl/qtree_loader_pkg.sv
// Shared types and constants for the QTree stream loader: token tags, FSM states
// and token field offsets.
package qtree_loader_pkg;

  typedef enum logic [1:0] {
    TAG_EMPTY = 2'd0,
    TAG_LEAF  = 2'd1,
    TAG_NODE  = 2'd2,
    TAG_FULL  = 2'd3
  } tag_e;

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_WAIT_PTR = 3'd2,
    ST_LAUNCH   = 3'd3,
    ST_RUN      = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

  localparam int TOK_TAG_LSB = 0;
  localparam int TOK_TAG_W   = 2;
  localparam int TOK_PAY_LSB = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/qtree_stream_loader_ptr_stack.sv
// Heap-pointer stack: single push, pop of pop_n entries, and a combinational
// view of the top PEEK_N entries (peek slot 0 is the top of stack).
module ptr_stack
  import qtree_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int W      = 16,
  parameter int PEEK_N = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  input  logic [SP_W-1:0]    pop_n,
  output logic [PEEK_N*W-1:0] peek,
  output logic [SP_W-1:0]    sp,
  output logic               full,
  output logic               underflow
);

  logic [W-1:0]    mem_r [DEPTH];
  logic [SP_W-1:0] sp_r;

  assign sp        = sp_r;
  assign full      = (sp_r == SP_W'(DEPTH));
  assign underflow = (sp_r < pop_n);

  // storage array, written at the current stack pointer on a legal push
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[sp_r[AW-1:0]] <= push_data;
    end
  end

  // stack pointer; push wins over pop, illegal operations leave it unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_r <= '0;
    end else if (push && !full) begin
      sp_r <= sp_r + SP_W'(1);
    end else if (pop && !underflow) begin
      sp_r <= sp_r - pop_n;
    end else begin
      sp_r <= sp_r;
    end
  end

  for (genvar j = 0; j < PEEK_N; j++) begin : g_peek
    logic [AW-1:0] idx_s;
    assign idx_s = sp_r[AW-1:0] - AW'(j + 1);
    assign peek[j*W +: W] = mem_r[idx_s];
  end

endmodule

// File: rtl/qtree_stream_loader.sv
// Loads NUM_ROOTS postfix-encoded trees into the heap, launches the dataflow DUT
// and captures its result. Optional counters: define QTREE_LOADER_STATS_EN.
module qtree_stream_loader
  import qtree_loader_pkg::*;
#(
  parameter int NUM_ROOTS   = 2,
  parameter int STACK_DEPTH = 256,
  parameter int PTR_W       = 16,
  parameter int VAL_W       = 64,
  parameter int ARITY       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [VAL_W+1:0]           s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [1:0]                 wr_tag,
  output logic [VAL_W-1:0]           wr_value,
  output logic [ARITY*PTR_W-1:0]     wr_children,
  input  logic                       ptr_valid,
  input  logic [PTR_W-1:0]           ptr_data,
  output logic                       go_valid,
  input  logic                       go_ready,
  output logic [NUM_ROOTS-1:0]       root_valid,
  input  logic [NUM_ROOTS-1:0]       root_ready,
  output logic [NUM_ROOTS*PTR_W-1:0] root_data,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [PTR_W-1:0]           res_data,
  output logic [PTR_W-1:0]           result_data,
  output logic                       result_valid,
  output logic                       error
`ifdef QTREE_LOADER_STATS_EN
  ,
  output logic [31:0]                stat_tokens,
  output logic [31:0]                stat_run_cycles
`endif
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W = 4;

  state_e                   state_r;
  logic                     tlast_r;
  logic                     s_tready_r;
  logic                     wr_valid_r;
  logic [1:0]               wr_tag_r;
  logic [VAL_W-1:0]         wr_value_r;
  logic [ARITY*PTR_W-1:0]   wr_children_r;
  logic                     go_valid_r;
  logic                     go_done_r;
  logic [NUM_ROOTS-1:0]     root_valid_r;
  logic [NUM_ROOTS-1:0]     root_done_r;
  logic [PTR_W-1:0]         roots_r [NUM_ROOTS];
  logic [CNT_W-1:0]         count_r;
  logic                     res_ready_r;
  logic [PTR_W-1:0]         result_data_r;
  logic                     result_valid_r;
  logic                     error_r;

  tag_e                     tok_tag_s;
  logic [VAL_W-1:0]         tok_pay_s;
  logic                     accept_s;
  logic                     is_node_s;
  logic                     push_s;
  logic                     pop_s;
  logic [ARITY*PTR_W-1:0]   peek_s;
  logic [ARITY*PTR_W-1:0]   children_s;
  logic [SP_W-1:0]          sp_s;
  logic                     full_s;
  logic                     underflow_s;
  logic                     go_hs_s;
  logic [NUM_ROOTS-1:0]     root_hs_s;
  logic                     launch_done_s;
  logic [CNT_W-1:0]         count_inc_s;

  assign tok_tag_s     = tag_e'(s_tdata[TOK_TAG_LSB +: TOK_TAG_W]);
  assign tok_pay_s     = s_tdata[TOK_PAY_LSB +: VAL_W];
  assign accept_s      = (state_r == ST_LOAD) && s_tready_r && s_tvalid;
  assign is_node_s     = (tok_tag_s == TAG_NODE);
  assign push_s        = (state_r == ST_WAIT_PTR) && ptr_valid && !tlast_r && !full_s;
  assign pop_s         = accept_s && is_node_s && !underflow_s;
  assign go_hs_s       = go_valid_r && go_ready;
  assign root_hs_s     = root_valid_r & root_ready;
  assign launch_done_s = (go_done_r || go_hs_s) && (&(root_done_r | root_hs_s));
  assign count_inc_s   = count_r + CNT_W'(1);

  ptr_stack #(
    .DEPTH  (STACK_DEPTH),
    .W      (PTR_W),
    .PEEK_N (ARITY)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (ptr_data),
    .pop       (pop_s),
    .pop_n     (SP_W'(ARITY)),
    .peek      (peek_s),
    .sp        (sp_s),
    .full      (full_s),
    .underflow (underflow_s)
  );

  // postfix order: the most recently pushed pointer is the last child
  always_comb begin
    children_s = '0;
    for (int i = 0; i < ARITY; i++) begin
      children_s[i*PTR_W +: PTR_W] = peek_s[(ARITY-1-i)*PTR_W +: PTR_W];
    end
  end

  // main control FSM with all handshake outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_LOAD;
      tlast_r        <= 1'b0;
      s_tready_r     <= 1'b0;
      wr_valid_r     <= 1'b0;
      wr_tag_r       <= 2'd0;
      wr_value_r     <= '0;
      wr_children_r  <= '0;
      go_valid_r     <= 1'b0;
      go_done_r      <= 1'b0;
      root_valid_r   <= '0;
      root_done_r    <= '0;
      count_r        <= '0;
      res_ready_r    <= 1'b0;
      result_data_r  <= '0;
      result_valid_r <= 1'b0;
      error_r        <= 1'b0;
      for (int r = 0; r < NUM_ROOTS; r++) begin
        roots_r[r] <= '0;
      end
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (accept_s) begin
            s_tready_r <= 1'b0;
            tlast_r    <= s_tlast;
            if (is_node_s && underflow_s) begin
              error_r <= 1'b1;
              state_r <= ST_ERR;
            end else begin
              wr_valid_r    <= 1'b1;
              wr_tag_r      <= tok_tag_s;
              wr_value_r    <= is_node_s ? '0 : tok_pay_s;
              wr_children_r <= is_node_s ? children_s : '0;
              state_r       <= ST_WRITE;
            end
          end else begin
            s_tready_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_ready) begin
            wr_valid_r <= 1'b0;
            state_r    <= ST_WAIT_PTR;
          end
        end
        ST_WAIT_PTR: begin
          if (ptr_valid) begin
            if (full_s || (tlast_r && (sp_s != '0))) begin
              error_r <= 1'b1;
              state_r <= ST_ERR;
            end else if (tlast_r) begin
              // pushing and immediately popping the root leaves sp unchanged
              for (int r = 0; r < NUM_ROOTS; r++) begin
                if (count_r == CNT_W'(r)) begin
                  roots_r[r] <= ptr_data;
                end
              end
              count_r <= count_inc_s;
              if (count_inc_s == CNT_W'(NUM_ROOTS)) begin
                go_valid_r   <= 1'b1;
                go_done_r    <= 1'b0;
                root_valid_r <= '1;
                root_done_r  <= '0;
                state_r      <= ST_LAUNCH;
              end else begin
                s_tready_r <= 1'b1;
                state_r    <= ST_LOAD;
              end
            end else begin
              s_tready_r <= 1'b1;
              state_r    <= ST_LOAD;
            end
          end
        end
        ST_LAUNCH: begin
          if (go_hs_s) begin
            go_valid_r <= 1'b0;
            go_done_r  <= 1'b1;
          end
          root_valid_r <= root_valid_r & ~root_ready;
          root_done_r  <= root_done_r | root_hs_s;
          if (launch_done_s) begin
            res_ready_r <= 1'b1;
            state_r     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (res_valid) begin
            result_data_r  <= res_data;
            result_valid_r <= 1'b1;
            res_ready_r    <= 1'b0;
            state_r        <= ST_DONE;
          end
        end
        ST_DONE: begin
          res_ready_r <= 1'b0;
        end
        ST_ERR: begin
          s_tready_r <= 1'b0;
          wr_valid_r <= 1'b0;
          error_r    <= 1'b1;
        end
        default: begin
          error_r <= 1'b1;
          state_r <= ST_ERR;
        end
      endcase
    end
  end

  assign s_tready     = s_tready_r;
  assign wr_valid     = wr_valid_r;
  assign wr_tag       = wr_tag_r;
  assign wr_value     = wr_value_r;
  assign wr_children  = wr_children_r;
  assign go_valid     = go_valid_r;
  assign root_valid   = root_valid_r;
  assign res_ready    = res_ready_r;
  assign result_data  = result_data_r;
  assign result_valid = result_valid_r;
  assign error        = error_r;

  for (genvar r = 0; r < NUM_ROOTS; r++) begin : g_root
    assign root_data[r*PTR_W +: PTR_W] = roots_r[r];
  end

`ifdef QTREE_LOADER_STATS_EN
  logic [31:0] stat_tokens_r;
  logic [31:0] stat_run_cycles_r;

  // saturating token and run-cycle counters; run count freezes once DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_tokens_r     <= 32'd0;
      stat_run_cycles_r <= 32'd0;
    end else begin
      stat_tokens_r     <= accept_s ? sat_inc32(stat_tokens_r) : stat_tokens_r;
      stat_run_cycles_r <= (state_r == ST_RUN) ? sat_inc32(stat_run_cycles_r)
                                               : stat_run_cycles_r;
    end
  end

  assign stat_tokens     = stat_tokens_r;
  assign stat_run_cycles = stat_run_cycles_r;
`endif

endmodule

// File: tb/tb_qtree_stream_loader.sv
// Directed table-driven bench for qtree_stream_loader with a simple heap responder.
module tb_qtree_stream_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [65:0]  s_tdata;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic         wr_valid;
  logic         wr_ready;
  logic [1:0]   wr_tag;
  logic [63:0]  wr_value;
  logic [63:0]  wr_children;
  logic         ptr_valid;
  logic [15:0]  ptr_data;
  logic         go_valid;
  logic         go_ready;
  logic [1:0]   root_valid;
  logic [1:0]   root_ready;
  logic [31:0]  root_data;
  logic         res_valid;
  logic         res_ready;
  logic [15:0]  res_data;
  logic [15:0]  result_data;
  logic         result_valid;
  logic         error;
`ifdef QTREE_LOADER_STATS_EN
  logic [31:0]  stat_tokens;
  logic [31:0]  stat_run_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qtree_stream_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_tdata      (s_tdata),
    .s_tlast      (s_tlast),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_tag       (wr_tag),
    .wr_value     (wr_value),
    .wr_children  (wr_children),
    .ptr_valid    (ptr_valid),
    .ptr_data     (ptr_data),
    .go_valid     (go_valid),
    .go_ready     (go_ready),
    .root_valid   (root_valid),
    .root_ready   (root_ready),
    .root_data    (root_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .result_data  (result_data),
    .result_valid (result_valid),
    .error        (error)
`ifdef QTREE_LOADER_STATS_EN
    ,
    .stat_tokens     (stat_tokens),
    .stat_run_cycles (stat_run_cycles)
`endif
  );

  typedef struct {
    logic        rst_before;
    logic [1:0]  tag;
    logic [63:0] pay;
    logic        last;
    logic [15:0] ptr;
    int          hold;
    logic [1:0]  exp_tag;
    logic [63:0] exp_val;
    logic [63:0] exp_ch;
    logic        exp_go;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_tdata   = '0;
    s_tlast   = 1'b0;
    s_tvalid  = 1'b0;
    wr_ready  = 1'b0;
    ptr_valid = 1'b0;
    ptr_data  = '0;
    go_ready  = 1'b0;
    root_ready = 2'b00;
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tready();
    int n = 0;
    while (s_tready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tready_wait", {63'd0, s_tready}, 64'd1);
  endtask

  task automatic apply(input int i);
    vec_t v;
    int n;
    v = vecs[i];
    if (v.rst_before) do_reset();
    wait_tready();
    s_tdata  = {v.pay, v.tag};
    s_tlast  = v.last;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    n = 0;
    while (wr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_wr_valid", i), {63'd0, wr_valid}, 64'd1);
    chk($sformatf("v%0d_wr_tag", i), {62'd0, wr_tag}, {62'd0, v.exp_tag});
    chk($sformatf("v%0d_wr_value", i), wr_value, v.exp_val);
    chk($sformatf("v%0d_wr_children", i), wr_children, v.exp_ch);
    if (v.hold > 0) begin
      repeat (v.hold) @(negedge clk);
      chk($sformatf("v%0d_stall_valid", i), {63'd0, wr_valid}, 64'd1);
      chk($sformatf("v%0d_stall_children", i), wr_children, v.exp_ch);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready  = 1'b0;
    ptr_valid = 1'b1;
    ptr_data  = v.ptr;
    @(negedge clk);
    ptr_valid = 1'b0;
    chk($sformatf("v%0d_go", i), {63'd0, go_valid}, {63'd0, v.exp_go});
    chk($sformatf("v%0d_err", i), {63'd0, error}, {63'd0, v.exp_err});
  endtask

  initial begin
    //         rst   tag    payload  last  ptr       hold  etag   eval     echildren                 go    err
    vecs[0]  = '{1'b1, 2'd1, 64'h5,  1'b1, 16'h0010, 0, 2'd1, 64'h5,  64'h0,                   1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 64'h7,  1'b1, 16'h0011, 0, 2'd1, 64'h7,  64'h0,                   1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 64'hA,  1'b0, 16'h0001, 0, 2'd1, 64'hA,  64'h0,                   1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 64'hB,  1'b0, 16'h0002, 0, 2'd1, 64'hB,  64'h0,                   1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 64'hC,  1'b0, 16'h0003, 0, 2'd1, 64'hC,  64'h0,                   1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 64'hD,  1'b0, 16'h0004, 0, 2'd1, 64'hD,  64'h0,                   1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 64'hFF, 1'b1, 16'h0005, 2, 2'd2, 64'h0,  64'h0004_0003_0002_0001, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 64'hE,  1'b1, 16'h0006, 0, 2'd1, 64'hE,  64'h0,                   1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 64'h33, 1'b0, 16'h0001, 0, 2'd0, 64'h33, 64'h0,                   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 64'h44, 1'b1, 16'h0002, 0, 2'd3, 64'h44, 64'h0,                   1'b0, 1'b1};
    vecs[10] = '{1'b1, 2'd1, 64'h1,  1'b0, 16'h0001, 0, 2'd1, 64'h1,  64'h0,                   1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 64'h2,  1'b0, 16'h0002, 0, 2'd1, 64'h2,  64'h0,                   1'b0, 1'b0};
    vecs[12] = '{1'b1, 2'd1, 64'h9,  1'b1, 16'h0030, 0, 2'd1, 64'h9,  64'h0,                   1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 64'h8,  1'b0, 16'h0031, 0, 2'd1, 64'h8,  64'h0,                   1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'd1, 64'h5,  1'b1, 16'h0020, 0, 2'd1, 64'h5,  64'h0,                   1'b0, 1'b0};
    vecs[15] = '{1'b0, 2'd1, 64'h7,  1'b1, 16'h0021, 0, 2'd1, 64'h7,  64'h0,                   1'b1, 1'b0};

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    chk("rst_go", {63'd0, go_valid}, 64'd0);
    chk("rst_root_valid", {62'd0, root_valid}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_result_valid", {63'd0, result_valid}, 64'd0);

    // two single-leaf trees, then the launch handshake and result capture
    apply(0);
    apply(1);
    chk("t1_root_data", {32'd0, root_data}, 64'h0011_0010);
    chk("t1_root_valid", {62'd0, root_valid}, 64'd3);
    chk("t1_tready", {63'd0, s_tready}, 64'd0);
    root_ready = 2'b01;
    @(negedge clk);
    root_ready = 2'b00;
    chk("l1_root_valid", {62'd0, root_valid}, 64'd2);
    chk("l1_go", {63'd0, go_valid}, 64'd1);
    @(negedge clk);
    chk("l2_root_valid", {62'd0, root_valid}, 64'd2);
    chk("l2_go", {63'd0, go_valid}, 64'd1);
    chk("l2_res_ready", {63'd0, res_ready}, 64'd0);
    go_ready   = 1'b1;
    root_ready = 2'b10;
    @(negedge clk);
    go_ready   = 1'b0;
    root_ready = 2'b00;
    chk("l3_go", {63'd0, go_valid}, 64'd0);
    chk("l3_root_valid", {62'd0, root_valid}, 64'd0);
    chk("l3_res_ready", {63'd0, res_ready}, 64'd1);
    res_data  = 16'h002A;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("res_valid", {63'd0, result_valid}, 64'd1);
    chk("res_data", {48'd0, result_data}, 64'h2A);
    chk("res_ready_done", {63'd0, res_ready}, 64'd0);
    res_data  = 16'h003B;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("res_sticky", {48'd0, result_data}, 64'h2A);

    // four leaves plus a node, then a second leaf tree
    for (int i = 2; i <= 7; i++) apply(i);
    chk("t2_root_data", {32'd0, root_data}, 64'h0006_0005);

    // empty/full tags and tlast leaving the stack non-empty
    apply(8);
    apply(9);
    chk("t3_tready_err", {63'd0, s_tready}, 64'd0);

    // node with only two pointers on the stack
    apply(10);
    apply(11);
    wait_tready();
    s_tdata  = {64'h0, 2'd2};
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("uf_error", {63'd0, error}, 64'd1);
    chk("uf_tready", {63'd0, s_tready}, 64'd0);
    chk("uf_wr_valid", {63'd0, wr_valid}, 64'd0);
    @(negedge clk);
    chk("uf_error_sticky", {63'd0, error}, 64'd1);
    reset = 1'b1;
    #1;
    chk("uf_rst_error", {63'd0, error}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("uf_rst_tready", {63'd0, s_tready}, 64'd1);

    // one tree done and a pointer stacked, then reset lands during WRITE
    apply(12);
    apply(13);
    wait_tready();
    s_tdata  = {64'h6, 2'd1};
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("mw_wr_valid", {63'd0, wr_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mw_rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    chk("mw_rst_tready", {63'd0, s_tready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply(14);
    apply(15);
    chk("t4_root_data", {32'd0, root_data}, 64'h0021_0020);
    chk("t4_result_valid", {63'd0, result_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qtree_stream_loader.md
Name: qtree_stream_loader

Overview:
- Parametrised successor to the single-purpose QTree input wrappers.
- Accepts N trees as a postfix AXI-stream token sequence and writes each node to the heap write channel. Returned pointers are kept on an internal stack; each tree's root pointer is latched at tlast.
- After N roots: launches go plus N root-pointer channels into the dataflow DUT, then captures the DUT's result pointer.
- Sits between host DMA/testbench stream and the generated DUT top.

Parameters:
NUM_ROOTS, 2, number of trees/root-pointer channels (1..8)
STACK_DEPTH, 256, pointer stack entries (power of 2)
PTR_W, 16, heap pointer width
VAL_W, 64, leaf payload width
ARITY, 4, children per internal node

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
s_tdata  in  VAL_W+2  token; [1:0] tag (0 empty, 1 leaf, 2 node, 3 full), [VAL_W+1:2] payload
s_tlast  in  1  last token of current tree
s_tvalid  in  1  token valid
s_tready  out  1  token accepted
wr_valid  out  1  heap write request
wr_ready  in  1  heap accepts write
wr_tag  out  2  node tag
wr_value  out  VAL_W  leaf payload (0 for node)
wr_children  out  ARITY*PTR_W  child pointers, child0 in LSBs
ptr_valid  in  1  heap returns allocated pointer
ptr_data  in  PTR_W  allocated pointer
go_valid/go_ready  out/in  1  start token to DUT
root_valid  out  NUM_ROOTS  per-root valid
root_ready  in  NUM_ROOTS  per-root ready
root_data  out  NUM_ROOTS*PTR_W  root pointers, root0 in LSBs
res_valid/res_ready  in/out  1  DUT result handshake
result_data  out  PTR_W  captured result pointer
result_valid  out  1  sticky: result captured
error  out  1  sticky protocol error

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-high, port `reset`.
- Reset values: all outputs 0; stack pointer 0; root count 0; FSM in LOAD.
- FSM states: LOAD, WRITE, WAIT_PTR, LAUNCH, RUN, DONE, ERR.
- LOAD:
  - s_tready=1.
  - On accept, form the write. Leaf/empty/full: tag and payload.
  - Node: children = stack[sp-1..sp-ARITY] in order, with stack[sp-1] as the LAST child (postfix: first child pushed first). sp -= ARITY.
  - Register tlast. Go to WRITE.
- WRITE:
  - wr_valid held with data stable until wr_ready, then go to WAIT_PTR.
  - s_tready=0.
- WAIT_PTR:
  - On ptr_valid, push ptr_data (sp += 1).
  - If the registered tlast is set: latch stack top into root[count], pop it, count += 1. If the resulting sp != 0, set error and go to ERR.
  - If count == NUM_ROOTS, go to LAUNCH; else go to LOAD.
- Latency: minimum 3 cycles per token (accept, write, pointer).
- LAUNCH:
  - go_valid and all root_valid assert together on entry.
  - Each channel deasserts independently on its own ready, with a per-channel done bit.
  - Go to RUN when all channels are done.
  - Simultaneous readies in one cycle are all honoured.
- RUN / DONE:
  - res_ready=1 in RUN.
  - On res_valid: result_data <= data, result_valid <= 1, go to DONE.
  - DONE holds until reset; res_ready=0 in DONE.
- Errors (state ERR; s_tready=0, wr_valid=0, error=1 until reset):
  - Node token with sp < ARITY (underflow).
  - Push with sp == STACK_DEPTH (overflow).
  - tlast leaving stack non-empty.
- ptr_valid outside WAIT_PTR is ignored.
- Reset asserted mid-operation clears everything asynchronously, including captured roots and result.
- Pointer arithmetic is modulo 2^PTR_W; no zero-pointer check.

Optional Feature:
- QTREE_LOADER_STATS_EN
  - Defined: adds outputs stat_tokens (32 b) and stat_run_cycles (32 b).
    - stat_tokens counts accepted tokens.
    - stat_run_cycles counts cycles in RUN; frozen in DONE.
    - Both saturate at all-ones and reset to 0.
  - Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package qtree_loader_pkg holds:
  - tag enum (TAG_EMPTY=0, TAG_LEAF=1, TAG_NODE=2, TAG_FULL=3);
  - FSM state enum;
  - token field-offset constants.
- Sub-module ptr_stack (parametrised by depth/width) provides push, pop-N, peek-N, and overflow/underflow flags.

Test Plan:
- Two single-leaf trees (leaf 5 tlast, leaf 7 tlast), heap returns ptrs 0x10/0x11 -> root_data = {0x11,0x10}; go plus both roots valid; error=0.
- One tree of 4 leaves then a node (ptrs 1..4 then 5) -> wr_children = {4,3,2,1} with child0=1; root0=5; sp=0 after tlast.
- LAUNCH with root_ready[0] at cycle 1, go_ready at cycle 3, root_ready[1] at cycle 3 -> each valid drops the cycle after its own ready; RUN entered after cycle 3.
- Node token with sp=2 -> error=1, s_tready=0; reset clears error and returns to LOAD.
- res_valid with data 0x2A in RUN -> result_data=0x2A, result_valid=1; a later res_valid with 0x3B does not change it.
- Reset pulsed during WRITE -> wr_valid=0 immediately, sp=0, root count 0; a fresh two-tree load then succeeds.
